// File: rtl/addmul_arbiter.sv
// Two-port arbiter in front of a shared add/multiply unit.
// One request is served at a time: add in 1 cycle, multiply in 3 shift-add steps.
module addmul_arbiter #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req1_valid,
    output logic       req0_ready,
    output logic       req1_ready,
    input  logic       req0_op,
    input  logic       req1_op,
    input  logic [2:0] req0_a,
    input  logic [2:0] req0_b,
    input  logic [2:0] req1_a,
    input  logic [2:0] req1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [5:0] rsp_data,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        MUL  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t     state;
    logic       last_grant;
    logic       op_reg;
    logic       id_reg;
    logic [2:0] a_reg;
    logic [2:0] b_reg;
    logic [5:0] acc;
    logic [1:0] step;

    logic       grant0;
    logic       grant1;
    logic       idle_ok;
    logic       accept;
    logic       sel_op;
    logic [2:0] sel_a;
    logic [2:0] sel_b;
    logic       step_bit;
    logic [5:0] partial;
    logic [5:0] add_x;
    logic [5:0] add_y;
    logic [5:0] add_out;

    // last_grant == 1 means port 1 was served most recently, so port 0 wins a tie.
    always_comb begin
        grant1 = 1'b0;
        if (ROUND_ROBIN != 0)
            grant1 = req1_valid && (!req0_valid || !last_grant);
        else
            grant1 = req1_valid && !req0_valid;
        grant0 = req0_valid && !grant1;
    end

    // Ready is gated by rst so nothing looks accepted while reset is held.
    assign idle_ok    = !rst && (state == IDLE);
    assign req0_ready = idle_ok && grant0;
    assign req1_ready = idle_ok && grant1;
    assign accept     = req0_ready || req1_ready;

    assign sel_op = grant1 ? req1_op : req0_op;
    assign sel_a  = grant1 ? req1_a  : req0_a;
    assign sel_b  = grant1 ? req1_b  : req0_b;

    always_comb begin
        case (step)
            2'd0:    step_bit = b_reg[0];
            2'd1:    step_bit = b_reg[1];
            default: step_bit = b_reg[2];
        endcase
        partial = step_bit ? ({3'b000, a_reg} << step) : 6'd0;
    end

    // Single adder shared by both operations: a+b for add, acc+partial for multiply.
    always_comb begin
        add_x   = op_reg ? {3'b000, a_reg} : acc;
        add_y   = op_reg ? {3'b000, b_reg} : partial;
        add_out = add_x + add_y;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rsp_valid  <= 1'b0;
            busy       <= 1'b0;
            rsp_data   <= 6'd0;
            rsp_id     <= 1'b0;
            acc        <= 6'd0;
            step       <= 2'd0;
            last_grant <= 1'b1;
            op_reg     <= 1'b0;
            id_reg     <= 1'b0;
            a_reg      <= 3'd0;
            b_reg      <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_reg     <= sel_op;
                        a_reg      <= sel_a;
                        b_reg      <= sel_b;
                        id_reg     <= grant1;
                        last_grant <= grant1;
                        acc        <= 6'd0;
                        step       <= 2'd0;
                        busy       <= 1'b1;
                        state      <= sel_op ? ADD : MUL;
                    end
                end
                ADD: begin
                    rsp_data  <= add_out;
                    rsp_id    <= id_reg;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                MUL: begin
                    acc <= add_out;
                    if (step == 2'd2) begin
                        rsp_data  <= add_out;
                        rsp_id    <= id_reg;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        step <= step + 2'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/addmul_arbiter.md
ADDMUL_ARBITER -- requirements
Module: addmul_arbiter

Interface
REQ-001 The block SHALL have parameter ROUND_ROBIN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with port 0 highest.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have ports req0_valid and req1_valid  input  1 each  a request is offered on that port.
REQ-005 The block SHALL have ports req0_ready and req1_ready  output  1 each  the request on that port is accepted this cycle.
REQ-006 The block SHALL have ports req0_op and req1_op  input  1 each  operation select: 1 = add, 0 = multiply.
REQ-007 The block SHALL have ports req0_a, req0_b, req1_a and req1_b  input  3 each  unsigned operands.
REQ-008 The block SHALL have port rsp_valid  output  1  a result is presented.
REQ-009 The block SHALL have port rsp_ready  input  1  the consumer takes the result this cycle.
REQ-010 The block SHALL have port rsp_id  output  1  the index of the requester that owns the result.
REQ-011 The block SHALL have port rsp_data  output  6  the result; an add result is zero-extended, with the carry in bit 3.
REQ-012 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 The block SHALL implement the FSM states IDLE, ADD, MUL and RESP, with one shared datapath used by one operation at a time.
REQ-014 In IDLE, the block SHALL grant at most one port; reqN_ready SHALL be combinational: high only when the state is IDLE, reqN_valid is high and port N is granted.
REQ-015 Arbitration with ROUND_ROBIN=1: when both ports are valid, the port not granted most recently SHALL win; when one port is valid, that port SHALL win; the last-grant pointer SHALL update only on an accept.
REQ-016 Arbitration with ROUND_ROBIN=0: port 0 SHALL win whenever req0_valid is high.
REQ-017 On an accept (valid && ready), the block SHALL register op, a, b and the port id, then go to ADD if op=1, else to MUL.
REQ-018 ADD state: the block SHALL register {2'b00, a+b} (a 4-bit sum) into the result and go to RESP after 1 cycle.
REQ-019 MUL state: the block SHALL run a shift-add sequence of exactly 3 cycles, using a 2-bit step counter with values 0, 1, 2.
REQ-020 MUL state, each step s: when b[s]=1, the block SHALL add (a << s) to a 6-bit accumulator that was cleared on accept; after step 2 it SHALL go to RESP.
REQ-021 Latency SHALL be measured from the accept edge to the first rsp_valid cycle: add = 1 cycle, multiply = 3 cycles; the multiply result SHALL equal a*b, with a maximum of 49.
REQ-022 RESP state: rsp_valid SHALL be 1, and rsp_data and rsp_id SHALL be held stable until rsp_ready is high; on that edge the block SHALL go to IDLE.
REQ-023 Back-pressure: while in RESP with rsp_ready low, the block SHALL stay in RESP indefinitely, and no new request SHALL be accepted.
REQ-024 Outside RESP, rsp_valid SHALL be 0; rsp_data and rsp_id SHALL hold their last value.
REQ-025 No request SHALL be accepted in the same cycle that a response completes; the next accept SHALL occur in IDLE at the earliest one cycle later.
REQ-026 Input operands SHALL be sampled only at accept; changes on the request ports during ADD, MUL or RESP SHALL have no effect on the result.

Reset
REQ-027 While rst is high, the block SHALL force the state to IDLE, and SHALL clear rsp_valid, req0_ready, req1_ready and busy to 0.
REQ-028 While rst is high, the block SHALL clear rsp_data to 0, rsp_id to 0, the accumulator to 0 and the step counter to 0.
REQ-029 On reset, the last-grant pointer SHALL be set to 1, so that port 0 wins the first contention.
REQ-030 Reset asserted mid-operation (ADD, MUL or RESP) SHALL abort the operation immediately; the pending result SHALL be discarded and SHALL never appear on rsp_valid.

Verification
REQ-031 Scenario: port 0 requests add a=7, b=7, with rsp_ready=1 -> rsp_valid is high 1 cycle after accept, with rsp_data=14 and rsp_id=0.
REQ-032 Scenario: port 1 requests multiply a=7, b=7 -> rsp_valid is high 3 cycles after accept, with rsp_data=49 and rsp_id=1; busy is high for 4 cycles.
REQ-033 Scenario: both ports hold valid continuously with ROUND_ROBIN=1 -> the grant order is 0, 1, 0, 1; with ROUND_ROBIN=0 the grant order is 0, 0, 0.
REQ-034 Scenario: multiply a=5, b=3 with rsp_ready held low for 10 cycles -> rsp_valid stays high with rsp_data=15 stable, req ready stays low, and the response completes on the first cycle rsp_ready is high.
REQ-035 Scenario: rst is pulsed during MUL step 1 -> the state is IDLE and rsp_valid=0 immediately; the next request is served normally, and the port 0 grant wins contention.
REQ-036 Scenario: exhaustive sweep over 64 operand pairs for each op -> add results match a+b and multiply results match a*b; request inputs changed after accept do not alter the result.
